// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address and the
// IF/ID pipeline register, with hold (load-use) and flush (redirect) control
// plus saturating debug counters for both events.
module fetch_ifid_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold_sig,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc_plus4,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // The single action taken on each rising edge, in priority order.
  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_FLUSH
  } action_e;

  action_e          action;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_plus4_q, pc_plus4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [31:0]      pc_next_seq;

  // Redirect targets are forced word-aligned, so the low bits carry no information.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  // Sequential fetch address; 32-bit modulo so 0xFFFF_FFFC wraps to 0.
  assign pc_next_seq = pc_q + 32'd4;

  // Pick the edge action: a redirect beats a hold because the redirecting
  // instruction is older than the stalled one. An X hold is deliberately not filtered.
  always_comb begin
    action = ACT_ADVANCE;
    if (branch_taken)   action = ACT_FLUSH;
    else if (!hold_sig) action = ACT_HOLD;
  end

  // Next-state for PC, IF/ID and counters according to the chosen action.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    unique case (action)
      ACT_FLUSH: begin
        pc_d       = {branch_target[31:2], 2'b00};
        instr_d    = 32'h0;
        pc_plus4_d = 32'h0;
        valid_d    = 1'b0;
        if (flush_q != CNT_MAX) flush_d = flush_q + 1'b1;
      end
      ACT_HOLD: begin
        if (stall_q != CNT_MAX) stall_d = stall_q + 1'b1;
      end
      default: begin
        pc_d       = pc_next_seq;
        instr_d    = imem_rdata;
        pc_plus4_d = pc_next_seq;
        valid_d    = 1'b1;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= PC_RESET;
      instr_q    <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign pc            = pc_q;
  assign imem_addr     = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus4 = pc_plus4_q;
  assign ifid_valid    = valid_q;
  assign stall_count   = stall_q;
  assign flush_count   = flush_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Self-checking bench for fetch_ifid_stage: directed test-plan steps, a
// randomized run against a behavioural model, and a second instance for
// PC wrap-around and counter saturation.
module tb_fetch_ifid_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- instance A: default parameters ----------------
  logic        reset_a, hold_a, bt_a;
  logic [31:0] target_a, rdata_a, addr_a, pc_a, instr_a, pp4_a;
  logic        valid_a;
  logic [15:0] stall_a, flush_a;

  fetch_ifid_stage dut_a (
    .clk(clk), .reset(reset_a), .hold_sig(hold_a), .branch_taken(bt_a),
    .branch_target(target_a), .imem_rdata(rdata_a), .imem_addr(addr_a),
    .pc(pc_a), .ifid_instr(instr_a), .ifid_pc_plus4(pp4_a),
    .ifid_valid(valid_a), .stall_count(stall_a), .flush_count(flush_a)
  );

  // ---------------- instance B: wrap and saturation ----------------
  logic        reset_b, hold_b, bt_b;
  logic [31:0] target_b, rdata_b, addr_b, pc_b, instr_b, pp4_b;
  logic        valid_b;
  logic [1:0]  stall_b, flush_b;

  fetch_ifid_stage #(.PC_RESET(32'hFFFF_FFFC), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset_b), .hold_sig(hold_b), .branch_taken(bt_b),
    .branch_target(target_b), .imem_rdata(rdata_b), .imem_addr(addr_b),
    .pc(pc_b), .ifid_instr(instr_b), .ifid_pc_plus4(pp4_b),
    .ifid_valid(valid_b), .stall_count(stall_b), .flush_count(flush_b)
  );

  // Instruction memory: the word stored at an address is address + 0x1000.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a + 32'h1000;
  endfunction

  assign rdata_a = mem(addr_a);
  assign rdata_b = mem(addr_b);

  // ---------------- reference model for instance A ----------------
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid;
  int          m_stall, m_flush;

  function automatic int sat_inc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    m_stall = 0; m_flush = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag);
    check({tag, ".pc"},    pc_a,              m_pc);
    check({tag, ".addr"},  addr_a,            m_pc);
    check({tag, ".instr"}, instr_a,           m_instr);
    check({tag, ".pp4"},   pp4_a,             m_pp4);
    check({tag, ".valid"}, 32'(valid_a),      32'(m_valid));
    check({tag, ".stall"}, 32'(stall_a),      32'(m_stall));
    check({tag, ".flush"}, 32'(flush_a),      32'(m_flush));
  endtask

  // Apply one rising edge to instance A with its current inputs, advancing the model.
  task automatic tick_a(input string tag);
    if (bt_a) begin
      m_pc = target_a & 32'hFFFF_FFFC;
      m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
      m_flush = sat_inc(m_flush, 65535);
    end else if (!hold_a) begin
      m_stall = sat_inc(m_stall, 65535);
    end else begin
      m_instr = mem(m_pc);
      m_pp4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
    @(posedge clk); #1;
    check_a(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_a = 1'b1; hold_a = 1'b1; bt_a = 1'b0; target_a = 32'h0;
    reset_b = 1'b1; hold_b = 1'b1; bt_b = 1'b0; target_b = 32'h0;
    model_reset();
    #12;
    check_a("reset");
    @(negedge clk); reset_a = 1'b0;

    // Reset release: first valid IF/ID carries the PC_RESET word.
    tick_a("adv0");
    check("first_instr", instr_a, 32'h1000);
    check("first_pp4",   pp4_a,   32'h4);
    tick_a("adv1");
    check("pc_before_hold", pc_a, 32'h8);

    // Hold for two edges at pc=8.
    hold_a = 1'b0;
    tick_a("hold0");
    tick_a("hold1");
    check("hold_pc",    pc_a,          32'h8);
    check("hold_stall", 32'(stall_a),  32'd2);
    hold_a = 1'b1;
    tick_a("unhold");
    check("unhold_instr", instr_a, 32'h1008);
    check("unhold_pc",    pc_a,    32'hC);
    tick_a("adv2");

    // Redirect at pc=16 to 0x43 (aligned to 0x40).
    check("pc_before_br", pc_a, 32'h10);
    bt_a = 1'b1; target_a = 32'h0000_0043;
    tick_a("flush");
    check("flush_pc",    pc_a,         32'h40);
    check("flush_valid", 32'(valid_a), 32'd0);
    check("flush_cnt",   32'(flush_a), 32'd1);
    bt_a = 1'b0;
    tick_a("after_flush");
    check("target_instr", instr_a, 32'h1040);

    // Redirect coinciding with a hold: redirect wins, no stall counted.
    bt_a = 1'b1; hold_a = 1'b0; target_a = 32'h0000_0102;
    tick_a("flush_hold");
    check("fh_pc",    pc_a,         32'h100);
    check("fh_stall", 32'(stall_a), 32'd2);
    check("fh_flush", 32'(flush_a), 32'd2);
    bt_a = 1'b0; hold_a = 1'b1;

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      bt_a     = ($urandom_range(7) == 0);
      hold_a   = ($urandom_range(3) != 0);
      target_a = $urandom;
      tick_a("rand");
    end

    // Async reset pulse between edges during a hold.
    bt_a = 1'b0; hold_a = 1'b0;
    tick_a("pre_rst_hold");
    #2 reset_a = 1'b1;
    #1;
    model_reset();
    check_a("async_rst");
    #1 reset_a = 1'b0; hold_a = 1'b1;
    tick_a("post_rst");

    // Instance B: PC wrap and 2-bit counter saturation.
    @(negedge clk); reset_b = 1'b0;
    check("b_reset_pc", pc_b, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("b_wrap_pc",    pc_b,    32'h0);
    check("b_wrap_pp4",   pp4_b,   32'h0);
    check("b_wrap_instr", instr_b, 32'h0000_0FFC);
    hold_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    check("b_stall_sat", 32'(stall_b), 32'd3);
    check("b_hold_pc",   pc_b,         32'h0);
    bt_b = 1'b1; target_b = 32'h0000_0020;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    check("b_flush_sat", 32'(flush_b), 32'd3);
    check("b_flush_pc",  pc_b,         32'h20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
